// File: rtl/cic_decim_ctrl.sv
// Sequencer for the CIC decimation datapath: programmable decimation tick, warm-up discard
// and a one-entry valid/ready holding register for settled filter output words.
module cic_decim_ctrl #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned RATIO_W = 8,
  parameter int unsigned WARMUP  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [RATIO_W-1:0] ratio,
  output logic               dec_tick,
  output logic               filt_rst,
  input  logic [DATA_W-1:0]  filt_data,
  output logic               sample_valid,
  output logic [DATA_W-1:0]  sample_data,
  input  logic               sample_ready,
  output logic               settled,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWarm = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  localparam int unsigned WarmW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WarmW-1:0] WarmLast = (WARMUP > 0) ? WarmW'(WARMUP - 1) : '0;

  logic [1:0]         state_q, state_d;
  logic [RATIO_W-1:0] phase_q, phase_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [WarmW-1:0]   warm_cnt_q, warm_cnt_d;
  logic               cap_pend_q, cap_pend_d;
  logic               tick_q, tick_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               overrun_q, overrun_d;

  // Sequencer: tick_q is registered so that it is high exactly while phase_q == ratio_q-1.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ratio_d    = ratio_q;
    warm_cnt_d = warm_cnt_q;
    cap_pend_d = 1'b0;
    tick_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          ratio_d    = (ratio < RATIO_W'(2)) ? RATIO_W'(2) : ratio;
          phase_d    = '0;
          warm_cnt_d = '0;
          state_d    = (WARMUP == 0) ? StRun : StWarm;
        end
      end
      StWarm, StRun: begin
        if (!enable) begin
          state_d = StIdle;
          phase_d = '0;
        end else begin
          phase_d = tick_q ? '0 : phase_q + RATIO_W'(1);
          tick_d  = (phase_d == ratio_q - RATIO_W'(1));
          if (tick_q) begin
            if (state_q == StWarm) begin
              warm_cnt_d = warm_cnt_q + WarmW'(1);
              if (warm_cnt_q == WarmLast) state_d = StRun;
            end else begin
              cap_pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register; a capture into a full register that is not being drained is dropped.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (cap_pend_q) begin
      if (!valid_q || sample_ready) begin
        data_d  = filt_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      ratio_q    <= '0;
      warm_cnt_q <= '0;
      cap_pend_q <= 1'b0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ratio_q    <= ratio_d;
      warm_cnt_q <= warm_cnt_d;
      cap_pend_q <= cap_pend_d;
      tick_q     <= tick_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dec_tick     = tick_q;
  assign filt_rst     = (state_q == StIdle);
  assign settled      = (state_q == StRun);
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: ratio table for tick timing plus hand-written sequences
// for warm-up, capture, overrun, handshake, idle return and asynchronous reset.
module tb_cic_decim_ctrl;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned RATIO_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [RATIO_W-1:0] ratio;
  logic               dec_tick;
  logic               filt_rst;
  logic [DATA_W-1:0]  filt_data;
  logic               sample_valid;
  logic [DATA_W-1:0]  sample_data;
  logic               sample_ready;
  logic               settled;
  logic               overrun;
  logic               clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  cic_decim_ctrl #(
    .DATA_W (DATA_W),
    .RATIO_W(RATIO_W),
    .WARMUP (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ratio       (ratio),
    .dec_tick    (dec_tick),
    .filt_rst    (filt_rst),
    .filt_data   (filt_data),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .settled     (settled),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  // Filter output stand-in: a distinct word every cycle.
  always @(posedge clk) cyc <= cyc + 1;
  assign filt_data = DATA_W'(cyc) ^ 24'hA50000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the number of cycles until dec_tick is seen, or -1 if the budget runs out.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dec_tick && n < max);
    if (!dec_tick) n = -1;
  endtask

  task automatic do_reset();
    enable       = 1'b0;
    sample_ready = 1'b0;
    clr_overrun  = 1'b0;
    rst          = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [RATIO_W-1:0] ratio_in;
    int                 period;
  } vec_t;

  vec_t vecs[6];
  int   n;
  int   tick_cnt;
  logic [DATA_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_b;

  initial begin
    vecs[0] = '{ratio_in: 8'd0,   period: 2};
    vecs[1] = '{ratio_in: 8'd1,   period: 2};
    vecs[2] = '{ratio_in: 8'd2,   period: 2};
    vecs[3] = '{ratio_in: 8'd5,   period: 5};
    vecs[4] = '{ratio_in: 8'd64,  period: 64};
    vecs[5] = '{ratio_in: 8'd255, period: 255};

    ratio = 8'd0;
    do_reset();
    check("rst_filt_rst", 32'(filt_rst), 32'd1);
    check("rst_dec_tick", 32'(dec_tick), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_settled", 32'(settled), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Tick latency and period per ratio; a ratio change while running must be ignored.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ratio  = vecs[i].ratio_in;
      enable = 1'b1;
      wait_tick(400, n);
      check($sformatf("first_tick_r%0d", vecs[i].ratio_in), 32'(n), 32'(vecs[i].period));
      check("filt_rst_running", 32'(filt_rst), 32'd0);
      ratio = 8'd7;
      wait_tick(400, n);
      check($sformatf("period_r%0d", vecs[i].ratio_in), 32'(n), 32'(vecs[i].period));
    end

    // Warm-up discard and first capture at ratio 64.
    do_reset();
    ratio        = 8'd64;
    sample_ready = 1'b1;
    enable       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(200, n);
      check($sformatf("warm_tick%0d", k), 32'(n), 32'd64);
      check($sformatf("warm_settled%0d", k), 32'(settled), 32'd0);
      check($sformatf("warm_valid%0d", k), 32'(sample_valid), 32'd0);
    end
    step(1);
    check("settled_after_warm", 32'(settled), 32'd1);
    wait_tick(200, n);
    check("run_tick1", 32'(n), 32'd63);
    step(1);
    check("valid_tick_plus1", 32'(sample_valid), 32'd0);
    exp_a = filt_data;
    step(1);
    check("valid_tick_plus2", 32'(sample_valid), 32'd1);
    check("data_first", 32'(sample_data), 32'(exp_a));
    step(1);
    check("consumed", 32'(sample_valid), 32'd0);
    check("data_holds", 32'(sample_data), 32'(exp_a));
    sample_ready = 1'b0;

    // Held word, second word dropped, overrun then cleared.
    wait_tick(200, n);
    step(1);
    exp_a = filt_data;
    step(1);
    check("hold_valid", 32'(sample_valid), 32'd1);
    check("hold_data", 32'(sample_data), 32'(exp_a));
    wait_tick(200, n);
    step(2);
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_data_kept", 32'(sample_data), 32'(exp_a));
    check("overrun_valid_kept", 32'(sample_valid), 32'd1);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("clr_data_kept", 32'(sample_data), 32'(exp_a));
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    check("held_accepted", 32'(sample_valid), 32'd0);

    // Capture coincident with a handshake replaces the word without dropping it.
    wait_tick(200, n);
    step(1);
    exp_a = filt_data;
    step(1);
    check("t5_first_valid", 32'(sample_valid), 32'd1);
    wait_tick(200, n);
    step(1);
    sample_ready = 1'b1;
    exp_b = filt_data;
    step(1);
    sample_ready = 1'b0;
    check("t5_valid_stays", 32'(sample_valid), 32'd1);
    check("t5_new_word", 32'(sample_data), 32'(exp_b));
    check("t5_no_overrun", 32'(overrun), 32'd0);

    // Return to idle with a held sample, then restart at ratio 16.
    enable = 1'b0;
    step(1);
    check("idle_filt_rst", 32'(filt_rst), 32'd1);
    check("idle_settled", 32'(settled), 32'd0);
    check("idle_valid_held", 32'(sample_valid), 32'd1);
    check("idle_data_held", 32'(sample_data), 32'(exp_b));
    tick_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (dec_tick) tick_cnt++;
    end
    check("idle_no_ticks", 32'(tick_cnt), 32'd0);
    check("idle_valid_still", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    check("idle_read", 32'(sample_valid), 32'd0);
    ratio  = 8'd16;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(100, n);
      check($sformatf("rewarm_tick%0d", k), 32'(n), 32'd16);
      check($sformatf("rewarm_settled%0d", k), 32'(settled), 32'd0);
    end
    step(1);
    check("resettled", 32'(settled), 32'd1);

    // Asynchronous reset mid-cycle with a held sample and overrun pending.
    do_reset();
    ratio  = 8'd2;
    enable = 1'b1;
    step(20);
    check("pre_rst_valid", 32'(sample_valid), 32'd1);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_filt_rst", 32'(filt_rst), 32'd1);
    check("async_valid", 32'(sample_valid), 32'd0);
    check("async_data", 32'(sample_data), 32'd0);
    check("async_overrun", 32'(overrun), 32'd0);
    check("async_settled", 32'(settled), 32'd0);
    check("async_tick", 32'(dec_tick), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    check("post_rst_idle", 32'(filt_rst), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
